// File: rtl/tone_sequencer_pkg.sv
// ============================================================
// Module  : tone_seq_pkg
// Purpose : shared state encoding and note-table entry type
// Revision: 1.0
// ============================================================
`default_nettype none

package tone_seq_pkg;

    localparam int C_PHASE_W = 16;
    localparam int C_DUR_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [C_PHASE_W-1:0] inc;
        logic [C_DUR_W-1:0]   dur;
    } note_t;

endpackage

`default_nettype wire

// File: rtl/tone_sequencer_if.sv
// ============================================================
// Module  : tone_sequencer_if
// Purpose : control, table-write and ROM-side signals of the sequencer
// Revision: 1.0
// ============================================================
`default_nettype none

interface tone_sequencer_if #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 7,
    parameter int ENTRIES = 8,
    parameter int DUR_W   = 16
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic               start;
    logic               stop;
    logic               loop;
    logic [IDX_W:0]     cfg_len;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_addr;
    logic [PHASE_W-1:0] cfg_inc;
    logic [DUR_W-1:0]   cfg_dur;
    logic [ADDR_W-1:0]  rom_addr;
    logic               neg;
    logic               sample_valid;
    logic [IDX_W-1:0]   note_idx;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, loop, cfg_len, cfg_we, cfg_addr, cfg_inc, cfg_dur,
        input  rom_addr, neg, sample_valid, note_idx, busy, done
    );

    modport slave (
        input  start, stop, loop, cfg_len, cfg_we, cfg_addr, cfg_inc, cfg_dur,
        output rom_addr, neg, sample_valid, note_idx, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/tone_sequencer_quadrant_fold.sv
// ============================================================
// Module  : quadrant_fold
// Purpose : phase -> mirrored quarter-ROM address, sign and valid
// Revision: 1.0
// ============================================================
`default_nettype none

module quadrant_fold #(
    parameter int ADDR_W = 7
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              tick,
    input  wire logic              clear,
    input  wire logic [ADDR_W+1:0] phase_top,
    output logic      [ADDR_W-1:0] rom_addr,
    output logic                   neg,
    output logic                   sample_valid
);

    logic [1:0]        w_quad;
    logic [ADDR_W-1:0] w_b;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_neg_pipe;
    logic              r_valid_pipe;
    logic              r_neg;
    logic              r_valid;

    assign w_quad = phase_top[ADDR_W+1 -: 2];
    assign w_b    = phase_top[ADDR_W-1:0];

    // sign/valid take one extra stage so they line up with the ROM's registered data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr   <= '0;
            r_neg_pipe   <= 1'b0;
            r_valid_pipe <= 1'b0;
            r_neg        <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            if (tick) begin
                r_rom_addr   <= w_quad[0] ? ~w_b : w_b;
                r_neg_pipe   <= w_quad[1];
                r_valid_pipe <= 1'b1;
            end else begin
                r_valid_pipe <= 1'b0;
                if (clear) begin
                    r_rom_addr <= '0;
                    r_neg_pipe <= 1'b0;
                end
            end
            r_neg   <= r_neg_pipe;
            r_valid <= r_valid_pipe;
        end
    end

    assign rom_addr     = r_rom_addr;
    assign neg          = r_neg;
    assign sample_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/tone_sequencer.sv
// ============================================================
// Module  : tone_sequencer
// Purpose : note-table player driving the quarter-wave sine ROM
// Revision: 1.0
// ============================================================
`default_nettype none

module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int PHASE_W    = C_PHASE_W,
    parameter int ADDR_W     = 7,
    parameter int ENTRIES    = 8,
    parameter int DUR_W      = C_DUR_W,
    parameter int SAMPLE_DIV = 1
) (
    input wire logic        clk,
    input wire logic        rst,
    tone_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W:0]   c_len_one  = (IDX_W+1)'(1);

    state_t             r_state;
    state_t             w_next;
    note_t              r_table [ENTRIES];
    note_t              w_entry;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_inc;
    logic [DUR_W-1:0]   r_dur;
    logic [DUR_W-1:0]   r_dur_cnt;
    logic [IDX_W-1:0]   r_note_idx;
    logic [IDX_W-1:0]   w_load_idx;
    logic [IDX_W:0]     r_len;
    logic               r_loop;
    logic [DIV_W-1:0]   r_div;
    logic               r_done;
    logic               w_tick;
    logic               w_dur_last;
    logic               w_note_end;
    logic               w_more;
    logic               w_load;
    logic               w_begin;
    logic               w_abort;

    // no reset on the table: contents survive rst by design
    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            r_table[bus.cfg_addr] <= '{inc: C_PHASE_W'(bus.cfg_inc), dur: C_DUR_W'(bus.cfg_dur)};
        end
    end

    assign w_entry    = r_table[w_load_idx];
    assign w_tick     = (r_state == PLAY) && !bus.stop && (r_div == c_div_last);
    assign w_dur_last = (r_dur == '0) ? (r_dur_cnt == '0) : (r_dur_cnt == r_dur - DUR_W'(1));
    assign w_note_end = w_tick && w_dur_last;
    assign w_more     = ({1'b0, r_note_idx} < (r_len - c_len_one));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_idx = '0;
        w_begin    = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.cfg_len != '0)) begin
                    w_next  = PLAY;
                    w_load  = 1'b1;
                    w_begin = 1'b1;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (w_note_end) begin
                    if (w_more) begin
                        w_load     = 1'b1;
                        w_load_idx = r_note_idx + IDX_W'(1);
                    end else if (r_loop) begin
                        w_load = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // phase is only cleared at playback start so note changes stay continuous
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_inc      <= '0;
            r_dur      <= '0;
            r_dur_cnt  <= '0;
            r_note_idx <= '0;
            r_len      <= '0;
            r_loop     <= 1'b0;
            r_div      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_begin) begin
                r_phase <= '0;
                r_div   <= '0;
                r_len   <= bus.cfg_len;
                r_loop  <= bus.loop;
            end else if (r_state == PLAY) begin
                r_div <= (r_div == c_div_last) ? '0 : r_div + DIV_W'(1);
                if (w_tick) begin
                    r_phase <= r_phase + r_inc;
                end
            end
            if (w_load) begin
                r_inc      <= PHASE_W'(w_entry.inc);
                r_dur      <= DUR_W'(w_entry.dur);
                r_dur_cnt  <= '0;
                r_note_idx <= w_load_idx;
            end else if (w_tick) begin
                r_dur_cnt <= r_dur_cnt + DUR_W'(1);
            end
        end
    end

    quadrant_fold #(
        .ADDR_W (ADDR_W)
    ) u_fold (
        .clk          (clk),
        .rst          (rst),
        .tick         (w_tick),
        .clear        (w_abort),
        .phase_top    (r_phase[PHASE_W-1 -: ADDR_W+2]),
        .rom_addr     (bus.rom_addr),
        .neg          (bus.neg),
        .sample_valid (bus.sample_valid)
    );

    assign bus.note_idx = r_note_idx;
    assign bus.busy     = (r_state == PLAY);
    assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tone_sequencer.sv
// ============================================================
// Module  : tb_tone_sequencer
// Purpose : bench for tone_sequencer, two instances (1 and 4 clocks per sample)
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, loop = 1'b0, cfg_we = 1'b0;
    logic [3:0]  cfg_len = '0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_inc = '0, cfg_dur = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tone_sequencer_if b1 ();
    tone_sequencer_if b2 ();

    assign b1.start = start;  assign b1.stop = stop;  assign b1.loop = loop;
    assign b1.cfg_len = cfg_len;  assign b1.cfg_we = cfg_we;  assign b1.cfg_addr = cfg_addr;
    assign b1.cfg_inc = cfg_inc;  assign b1.cfg_dur = cfg_dur;
    assign b2.start = start;  assign b2.stop = stop;  assign b2.loop = loop;
    assign b2.cfg_len = cfg_len;  assign b2.cfg_we = cfg_we;  assign b2.cfg_addr = cfg_addr;
    assign b2.cfg_inc = cfg_inc;  assign b2.cfg_dur = cfg_dur;

    tone_sequencer #(.SAMPLE_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    tone_sequencer #(.SAMPLE_DIV(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    // Monitor: pairs each sample_valid with the address presented one cycle
    // earlier (what a registered ROM would return) and the note of the tick cycle.
    int cyc = 0;
    int q1_addr[$], q1_neg[$], q1_idx[$], q1_cyc[$];
    int q2_addr[$], q2_neg[$], q2_idx[$], q2_cyc[$];
    int d1_cnt = 0, d1_cyc = 0, d2_cnt = 0, d2_cyc = 0;
    int p1_addr = 0, p2_addr = 0, h1a = 0, h1b = 0, h2a = 0, h2b = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (b1.sample_valid) begin
            q1_addr.push_back(p1_addr); q1_neg.push_back(int'(b1.neg));
            q1_idx.push_back(h1b);      q1_cyc.push_back(cyc);
        end
        if (b2.sample_valid) begin
            q2_addr.push_back(p2_addr); q2_neg.push_back(int'(b2.neg));
            q2_idx.push_back(h2b);      q2_cyc.push_back(cyc);
        end
        if (b1.done) begin d1_cnt++; d1_cyc = cyc; end
        if (b2.done) begin d2_cnt++; d2_cyc = cyc; end
        h1b = h1a; h1a = int'(b1.note_idx); p1_addr = int'(b1.rom_addr);
        h2b = h2a; h2a = int'(b2.note_idx); p2_addr = int'(b2.rom_addr);
    end

    // Reference model: note table mirror and the expected sample stream.
    int m_inc[8], m_dur[8];
    int e_addr[$], e_neg[$], e_idx[$];

    task automatic build_model(input int len, input bit lp, input int limit);
        int ph = 0;
        int n = 0;
        int i = 0;
        int quad, pos, d;
        e_addr.delete(); e_neg.delete(); e_idx.delete();
        while (n < limit) begin
            d = (m_dur[i] == 0) ? 1 : m_dur[i];
            for (int k = 0; k < d && n < limit; k++) begin
                quad = ph / 16384;
                pos  = (ph % 16384) / 128;
                e_addr.push_back((quad % 2 == 1) ? 127 - pos : pos);
                e_neg.push_back(quad >= 2 ? 1 : 0);
                e_idx.push_back(i);
                ph = (ph + m_inc[i]) % 65536;
                n++;
            end
            i++;
            if (i == len) begin
                if (lp) i = 0;
                else break;
            end
        end
    endtask

    task automatic clear_obs();
        q1_addr.delete(); q1_neg.delete(); q1_idx.delete(); q1_cyc.delete();
        q2_addr.delete(); q2_neg.delete(); q2_idx.delete(); q2_cyc.delete();
        d1_cnt = 0; d2_cnt = 0; d1_cyc = 0; d2_cyc = 0;
    endtask

    task automatic write_entry(input int idx, input int inc, input int dur);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 3'(idx); cfg_inc = 16'(inc); cfg_dur = 16'(dur);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_inc[idx] = inc % 65536;
        m_dur[idx] = dur % 65536;
    endtask

    task automatic start_seq(input int len, input bit lp);
        @(posedge clk); #1;
        clear_obs();
        cfg_len = 4'(len); loop = lp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!b1.busy && !b2.busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({b1.rom_addr, b1.neg, b1.sample_valid, b1.note_idx, b1.busy, b1.done} !== 14'd0) begin
            bad++;
            $display("FAIL reset_dut1: got addr=%0d neg=%0d sv=%0d idx=%0d busy=%0d done=%0d, want all 0",
                     b1.rom_addr, b1.neg, b1.sample_valid, b1.note_idx, b1.busy, b1.done);
        end
        total++;
        if ({b2.rom_addr, b2.neg, b2.sample_valid, b2.note_idx, b2.busy, b2.done} !== 14'd0) begin
            bad++;
            $display("FAIL reset_dut2: got addr=%0d neg=%0d sv=%0d idx=%0d busy=%0d done=%0d, want all 0",
                     b2.rom_addr, b2.neg, b2.sample_valid, b2.note_idx, b2.busy, b2.done);
        end
    endtask

    task automatic test_single_note();
        bit ok;
        write_entry(0, 'h80, 512);
        build_model(1, 1'b0, 100000);
        start_seq(1, 1'b0);
        wait_idle(3000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout: busy never fell within budget"); end
        total++;
        if (q1_addr.size() != 512) begin
            bad++; $display("FAIL single_count: got %0d samples, want 512", q1_addr.size());
        end
        for (int k = 0; k < e_addr.size() && k < q1_addr.size(); k++) begin
            total++;
            if (q1_addr[k] !== e_addr[k] || q1_neg[k] !== e_neg[k] || q1_idx[k] !== e_idx[k]) begin
                bad++;
                $display("FAIL single_sample[%0d]: got addr=%0d neg=%0d idx=%0d, want addr=%0d neg=%0d idx=%0d",
                         k, q1_addr[k], q1_neg[k], q1_idx[k], e_addr[k], e_neg[k], e_idx[k]);
            end
        end
        total++;
        if (d1_cnt != 1) begin bad++; $display("FAIL single_done_count: got %0d, want 1", d1_cnt); end
        total++;
        if (q1_cyc.size() == 0 || d1_cyc != q1_cyc[q1_cyc.size()-1]) begin
            bad++; $display("FAIL single_done_align: done at cycle %0d, want cycle of last sample", d1_cyc);
        end
        total++;
        if (b1.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %0d, want 0", b1.busy); end
    endtask

    task automatic test_note_step();
        bit ok;
        write_entry(0, 'h100, 3);
        write_entry(1, 'h200, 2);
        build_model(2, 1'b0, 100000);
        start_seq(2, 1'b0);
        wait_idle(200, ok);
        total++;
        if (!ok || q1_addr.size() != 5) begin
            bad++; $display("FAIL step_count: got %0d samples (idle=%0d), want 5", q1_addr.size(), ok);
        end
        for (int k = 0; k < e_addr.size() && k < q1_addr.size(); k++) begin
            total++;
            if (q1_addr[k] !== e_addr[k] || q1_neg[k] !== e_neg[k] || q1_idx[k] !== e_idx[k]) begin
                bad++;
                $display("FAIL step_sample[%0d]: got addr=%0d neg=%0d idx=%0d, want addr=%0d neg=%0d idx=%0d",
                         k, q1_addr[k], q1_neg[k], q1_idx[k], e_addr[k], e_neg[k], e_idx[k]);
            end
        end
        total++;
        if (d1_cnt != 1) begin bad++; $display("FAIL step_done: got %0d pulses, want 1", d1_cnt); end
    endtask

    task automatic test_loop_stop();
        bit ok;
        int s_cyc, trail;
        build_model(2, 1'b1, 12);
        start_seq(2, 1'b1);
        repeat (12) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        s_cyc = cyc;
        total++;
        if (b1.busy !== 1'b0) begin bad++; $display("FAIL loop_busy_fall: got %0d, want 0", b1.busy); end
        wait_idle(200, ok);
        repeat (4) @(negedge clk);
        total++;
        if (!ok || q1_addr.size() != 12) begin
            bad++; $display("FAIL loop_count: got %0d samples (idle=%0d), want 12", q1_addr.size(), ok);
        end
        for (int k = 0; k < e_addr.size() && k < q1_addr.size(); k++) begin
            total++;
            if (q1_addr[k] !== e_addr[k] || q1_neg[k] !== e_neg[k] || q1_idx[k] !== e_idx[k]) begin
                bad++;
                $display("FAIL loop_sample[%0d]: got addr=%0d neg=%0d idx=%0d, want addr=%0d neg=%0d idx=%0d",
                         k, q1_addr[k], q1_neg[k], q1_idx[k], e_addr[k], e_neg[k], e_idx[k]);
            end
        end
        trail = 0;
        foreach (q1_cyc[k]) if (q1_cyc[k] > s_cyc) trail++;
        total++;
        if (trail > 1) begin bad++; $display("FAIL loop_trailing: got %0d samples after stop, want at most 1", trail); end
        total++;
        if (d1_cnt != 0 || d2_cnt != 0) begin
            bad++; $display("FAIL loop_no_done: got %0d/%0d done pulses, want 0", d1_cnt, d2_cnt);
        end
        total++;
        if (b1.rom_addr !== 7'd0) begin bad++; $display("FAIL loop_addr_clear: got %0d, want 0", b1.rom_addr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        write_entry(0, 'h100, 3);
        write_entry(1, 'h200, 2);
        start_seq(2, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({b1.rom_addr, b1.neg, b1.sample_valid, b1.note_idx, b1.busy, b1.done} !== 14'd0) begin
            bad++;
            $display("FAIL rstmid_outputs: got addr=%0d neg=%0d sv=%0d idx=%0d busy=%0d done=%0d, want all 0",
                     b1.rom_addr, b1.neg, b1.sample_valid, b1.note_idx, b1.busy, b1.done);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (d1_cnt != 0 || d2_cnt != 0) begin
            bad++; $display("FAIL rstmid_no_done: got %0d/%0d done pulses, want 0", d1_cnt, d2_cnt);
        end
        build_model(2, 1'b0, 100000);
        start_seq(2, 1'b0);
        wait_idle(200, ok);
        total++;
        if (!ok || q1_addr.size() != 5) begin
            bad++; $display("FAIL rstmid_replay_count: got %0d samples (idle=%0d), want 5", q1_addr.size(), ok);
        end
        for (int k = 0; k < e_addr.size() && k < q1_addr.size(); k++) begin
            total++;
            if (q1_addr[k] !== e_addr[k] || q1_neg[k] !== e_neg[k] || q1_idx[k] !== e_idx[k]) begin
                bad++;
                $display("FAIL rstmid_sample[%0d]: got addr=%0d neg=%0d idx=%0d, want addr=%0d neg=%0d idx=%0d",
                         k, q1_addr[k], q1_neg[k], q1_idx[k], e_addr[k], e_neg[k], e_idx[k]);
            end
        end
    endtask

    task automatic test_pacing();
        bit ok;
        write_entry(0, 'h1234, 3);
        build_model(1, 1'b0, 100000);
        start_seq(1, 1'b0);
        wait_idle(200, ok);
        total++;
        if (!ok || q2_addr.size() != 3) begin
            bad++; $display("FAIL pace_count: got %0d samples (idle=%0d), want 3", q2_addr.size(), ok);
        end
        for (int k = 0; k < e_addr.size() && k < q2_addr.size(); k++) begin
            total++;
            if (q2_addr[k] !== e_addr[k] || q2_neg[k] !== e_neg[k] || q2_idx[k] !== e_idx[k]) begin
                bad++;
                $display("FAIL pace_sample[%0d]: got addr=%0d neg=%0d idx=%0d, want addr=%0d neg=%0d idx=%0d",
                         k, q2_addr[k], q2_neg[k], q2_idx[k], e_addr[k], e_neg[k], e_idx[k]);
            end
        end
        for (int k = 1; k < q2_cyc.size(); k++) begin
            total++;
            if (q2_cyc[k] - q2_cyc[k-1] != 4) begin
                bad++; $display("FAIL pace_interval[%0d]: got %0d cycles, want 4", k, q2_cyc[k] - q2_cyc[k-1]);
            end
        end
        total++;
        if (d2_cnt != 1) begin bad++; $display("FAIL pace_done: got %0d pulses, want 1", d2_cnt); end
    endtask

    task automatic test_edges();
        bit ok;
        start_seq(0, 1'b0);
        repeat (5) @(negedge clk);
        total++;
        if (b1.busy !== 1'b0 || b2.busy !== 1'b0 || q1_addr.size() != 0) begin
            bad++; $display("FAIL edge_len0: got busy=%0d samples=%0d, want busy=0 samples=0", b1.busy, q1_addr.size());
        end
        @(posedge clk); #1;
        clear_obs();
        cfg_len = 4'd1; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (b1.busy !== 1'b0 || b2.busy !== 1'b0 || q1_addr.size() != 0) begin
            bad++; $display("FAIL edge_start_stop: got busy=%0d samples=%0d, want busy=0 samples=0", b1.busy, q1_addr.size());
        end
        write_entry(0, 'h1234, 0);
        build_model(1, 1'b0, 100000);
        start_seq(1, 1'b0);
        wait_idle(100, ok);
        total++;
        if (!ok || q1_addr.size() != 1 || d1_cnt != 1) begin
            bad++; $display("FAIL edge_dur0: got %0d samples %0d done, want 1 sample 1 done", q1_addr.size(), d1_cnt);
        end
        write_entry(0, 'hFFFF, 3);
        build_model(1, 1'b0, 100000);
        start_seq(1, 1'b0);
        wait_idle(100, ok);
        total++;
        if (!ok || q1_addr.size() != 3) begin
            bad++; $display("FAIL edge_wrap_count: got %0d samples, want 3", q1_addr.size());
        end
        for (int k = 0; k < e_addr.size() && k < q1_addr.size(); k++) begin
            total++;
            if (q1_addr[k] !== e_addr[k] || q1_neg[k] !== e_neg[k]) begin
                bad++;
                $display("FAIL edge_wrap[%0d]: got addr=%0d neg=%0d, want addr=%0d neg=%0d",
                         k, q1_addr[k], q1_neg[k], e_addr[k], e_neg[k]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int len;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) write_entry(i, int'($urandom % 65536), int'($urandom_range(0, 4)));
            len = int'($urandom_range(1, 8));
            build_model(len, 1'b0, 100000);
            start_seq(len, 1'b0);
            wait_idle(1000, ok);
            total++;
            if (!ok || q1_addr.size() != e_addr.size() || d1_cnt != 1) begin
                bad++;
                $display("FAIL rand%0d_count: got %0d samples %0d done, want %0d samples 1 done",
                         it, q1_addr.size(), d1_cnt, e_addr.size());
            end
            for (int k = 0; k < e_addr.size() && k < q1_addr.size(); k++) begin
                total++;
                if (q1_addr[k] !== e_addr[k] || q1_neg[k] !== e_neg[k] || q1_idx[k] !== e_idx[k]) begin
                    bad++;
                    $display("FAIL rand%0d_sample[%0d]: got addr=%0d neg=%0d idx=%0d, want addr=%0d neg=%0d idx=%0d",
                             it, k, q1_addr[k], q1_neg[k], q1_idx[k], e_addr[k], e_neg[k], e_idx[k]);
                end
            end
            for (int k = 0; k < e_addr.size() && k < q2_addr.size(); k++) begin
                total++;
                if (q2_addr[k] !== e_addr[k] || q2_neg[k] !== e_neg[k] || q2_idx[k] !== e_idx[k]) begin
                    bad++;
                    $display("FAIL rand%0d_div4[%0d]: got addr=%0d neg=%0d idx=%0d, want addr=%0d neg=%0d idx=%0d",
                             it, k, q2_addr[k], q2_neg[k], q2_idx[k], e_addr[k], e_neg[k], e_idx[k]);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_note();
        test_note_step();
        test_loop_stop();
        test_reset_mid();
        test_pacing();
        test_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
